fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of syn_fifo: drains bytes from the FIFO read port and serialises them as 8N1-style UART frames.
//  Pulls one word per frame via fifo_rden/fifo_empty and drives the tx line idle-high.
//  Sits between the FIFO and the board TX pin; lets firmware/producers burst data into the FIFO without pacing.
// PARAMETERS
//  DATA_WIDTH  8    width of FIFO word = data bits per frame (5..9)
//  CLK_DIV     868  clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  PARITY_EN   0    1 = append even-parity bit after data bits
//  STOP_BITS   1    number of stop bits (1 or 2)
// PORTS
//  clk         in   1           system clock; all logic on posedge
//  rst         in   1           synchronous, active-high reset
//  enable      in   1           1 = allowed to start new frames
//  fifo_dout   in   DATA_WIDTH  syn_fifo read data, valid the cycle after an accepted read
//  fifo_empty  in   1           syn_fifo empty flag
//  fifo_rden   out  1           read strobe to syn_fifo (single-cycle pulse)
//  tx          out  1           serial line, idle high
//  busy        out  1           1 from fetch until end of last stop bit
// BEHAVIOUR
//  Reset: tx=1, fifo_rden=0, busy=0, state=IDLE, baud/bit counters=0; shift reg cleared. Reset mid-frame aborts it: tx=1 on the next edge, byte dropped.
//  States: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE|FETCH.
//  IDLE: if enable & ~fifo_empty -> FETCH. fifo_rden is registered; high for exactly the FETCH cycle.
//  FETCH: no empty re-check; the read was qualified in IDLE. Next -> LOAD.
//  LOAD: capture fifo_dout into shift reg; compute even parity (^data). Next -> START.
//  START: tx=0 for CLK_DIV cycles. DATA: LSB first, each bit CLK_DIV cycles, bit counter 0..DATA_WIDTH-1.
//  PARITY (PARITY_EN only): tx=^data for CLK_DIV cycles. STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
//  Baud counter counts CLK_DIV-1 down to 0 and reloads on each bit boundary; width $clog2(CLK_DIV).
//  End of STOP: if enable & ~fifo_empty -> FETCH directly (back-to-back), else IDLE.
//  Inter-frame gap = 2 clk idle-high (FETCH+LOAD).
//  Frame length = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLK_DIV clks from START entry.
//  busy=1 in every state except IDLE; goes 0 the cycle IDLE is entered.
//  enable deasserted mid-frame: current frame completes; no further fetch.
//  fifo_empty rising mid-frame: ignored until the frame ends.
//  fifo_rden never asserts while fifo_empty=1 or rst=1; at most one read per frame; never two consecutive cycles.
//  tx is a registered output (glitch-free); changes only on bit boundaries and on reset.
// STRUCTURE
//  Shared header uart_defs.vh: state encodings (localparam ST_IDLE..ST_STOP), PARITY_EVEN constant.
//  One sub-module: uart_baud_tick (CLK_DIV down-counter, sync rst, load input, tick output); reused by a future RX.
//  FSM, shift register and bit counter in the top module.
// TESTING (sim with CLK_DIV=4, DATA_WIDTH=8 unless stated)
//  1 rst=1 with fifo_empty=0, enable=1 -> tx=1, busy=0, fifo_rden=0 for every rst cycle.
//  2 one byte 0xA5, PARITY_EN=0 -> one rden pulse; 2 clks later tx=0 x4, then bits 1,0,1,0,0,1,0,1 x4 each, then 1 x4; busy=1 for 42 clks.
//  3 FIFO preloaded 0x00..0x04, enable=1 -> exactly 5 rden pulses; 5 frames in order; 2-clk high gaps; decoded bytes match.
//  4 PARITY_EN=1, byte 0x07 -> parity bit=1; byte 0x03 -> parity bit=0; frame 44 clks.
//  5 STOP_BITS=2, byte 0xFF -> stop high 8 clks before the next FETCH; no rden while fifo_empty=1.
//  6 rst pulsed during DATA bit 3 -> tx=1 next edge, busy=0; after release, resumes with the next FIFO word.
//  7 enable dropped during START with 3 words queued -> current frame completes; no rden until enable returns.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx shared definitions.
// Transmitter FSM state encoding and parity seed.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // XOR seed folded into the data reduction; 0 yields even parity.
    localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// UART bit-period down-counter.
// load restarts a full bit period; tick marks its last cycle.
module fifo_uart_tx_baud_tick #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter.
// Pulls one FIFO word per frame and serialises it LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic                  par, par_n;
    logic                  tx_q, tx_n;
    logic                  rden_q, rden_n;
    logic                  baud_load;
    logic                  tick;
    logic                  start_ok;

    assign start_ok = enable & ~fifo_empty;

    fifo_uart_tx_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .load(baud_load),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            tx_q    <= 1'b1;
            rden_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            par     <= par_n;
            tx_q    <= tx_n;
            rden_q  <= rden_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        par_n     = par;
        tx_n      = tx_q;
        rden_n    = 1'b0;
        baud_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (start_ok) begin
                    state_n = ST_FETCH;
                    rden_n  = 1'b1;
                end
            end
            ST_FETCH: begin
                state_n = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_n   = fifo_dout;
                par_n     = (^fifo_dout) ^ PARITY_EVEN;
                tx_n      = 1'b0;
                bit_cnt_n = '0;
                baud_load = 1'b1;
                state_n   = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    baud_load = 1'b1;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    baud_load = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (PARITY_EN != 0) begin
                            tx_n    = par;
                            state_n = ST_PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = ST_STOP;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_n      = 1'b1;
                    baud_load = 1'b1;
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    // bit_cnt doubles as the stop-bit counter here
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_n = '0;
                        if (start_ok) begin
                            state_n = ST_FETCH;
                            rden_n  = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        baud_load = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign fifo_rden = rden_q & ~rst;
    assign tx        = tx_q;
    assign busy      = (state != ST_IDLE);

endmodule
